rs_err_injector: RTL and testbench
==================================

RS_ERR_INJECTOR -- requirements
Module: rs_err_injector

Interface
REQ-001 SHALL have parameter SYM_W, default 4, meaning symbol width in bits.
REQ-002 SHALL have parameter FRAME_LEN, default 15, meaning symbols per codeword frame (2..255).
REQ-003 SHALL have parameter MAX_ERR, default 2, meaning error-table entries and per-frame error cap (1..8).
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning 16-bit random-mode seed; a zero seed is replaced by 16'h0001.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-007 SHALL have port start_impulse, input, 1, frame start request, sampled on clk.
REQ-008 SHALL have port data_in, input, SYM_W, encoder symbol stream.
REQ-009 SHALL have port mode, input, 2, 00 pass-through, 01 fixed table, 10 random, 11 treated as 00.
REQ-010 SHALL have ports cfg_we (1), cfg_idx (clog2(MAX_ERR), min 1), cfg_pos (8), cfg_pat (SYM_W), cfg_en (1), inputs, a table-entry write port.
REQ-011 SHALL have port rnd_thr, input, 8, random-mode per-symbol injection threshold.
REQ-012 SHALL have port data_out, output, SYM_W, symbol after error injection.
REQ-013 SHALL have port err, output, 1, high with data_out when that symbol was corrupted.
REQ-014 SHALL have port start_imp, output, 1, one-cycle decoder start, coincident with symbol 0 on data_out.
REQ-015 SHALL have ports busy, frame_done, overrun (1 each) and err_cnt (clog2(MAX_ERR+1)), outputs.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; IDLE -> RUN when start_impulse=1.
REQ-017 In RUN, sym_idx SHALL count 0..FRAME_LEN-1, one symbol per clk; at FRAME_LEN-1 go to DONE.
REQ-018 DONE SHALL last one cycle with frame_done=1; err_cnt holds the frame total until the next frame starts.
REQ-019 data_out/err SHALL be registered: data_out = data_in XOR mask, 1-cycle latency from data_in at sym_idx.
REQ-020 On IDLE->RUN the module SHALL latch mode, rnd_thr and the whole table into shadow registers; cfg writes during a frame affect only the next frame.
REQ-021 Fixed mode: mask = XOR of cfg_pat of every enabled shadow entry with pos == sym_idx; entries with pos >= FRAME_LEN never fire.
REQ-022 Random mode: LFSR (x^16+x^14+x^13+x^11+1) SHALL step once per RUN symbol; inject when LFSR[7:0] < rnd_thr and err_cnt < MAX_ERR; mask = LFSR[SYM_W+7:8], forced to 1 if zero.
REQ-023 err SHALL equal (mask != 0); err_cnt SHALL increment per corrupted symbol, saturating at MAX_ERR.
REQ-024 Pass-through mode and IDLE/DONE SHALL output data_in registered with err=0.
REQ-025 start_impulse while busy (RUN or DONE) SHALL be ignored and set sticky overrun; start_impulse in the DONE cycle is an overrun.
REQ-026 busy SHALL be 1 in RUN and DONE.

Reset
REQ-027 rst SHALL immediately force IDLE, sym_idx=0, data_out=0, err=0, start_imp=0, busy=0, frame_done=0, overrun=0, err_cnt=0.
REQ-028 rst SHALL clear all table entries (en=0, pos=0, pat=0) and load LFSR with the seed; a reset mid-frame abandons the frame without frame_done.

Structure
REQ-029 Mode encodings, FSM state typedef and LFSR taps/default seed SHALL live in shared package rs_codec_pkg.
REQ-030 The LFSR SHALL be a separate sub-module rs_lfsr16 (clk, rst, step, seed, q).

Verification
REQ-031 Fixed mode, entries {0: pos 1 pat 4'b1000 en}, {1: pos 4 pat 4'b1000 en}, data_in=4'h5 constant -> err high on symbols 1 and 4 only, data_out=4'hD there, err_cnt=2, frame_done 16 cycles after start.
REQ-032 Both entries pos 3, pats 4'h3 and 4'h3 -> symbol 3 data_out=data_in, err=0, err_cnt=0.
REQ-033 Random mode rnd_thr=8'hFF, MAX_ERR=2 -> exactly symbols 0 and 1 corrupted, err_cnt=2; rnd_thr=0 -> no errors.
REQ-034 start_impulse re-pulsed at symbol 7 -> frame length unchanged, overrun=1 until rst.
REQ-035 cfg write pos 2 at symbol 5 of frame N -> no effect in frame N, symbol 2 corrupted in frame N+1.
REQ-036 rst asserted at symbol 9 -> all outputs 0 asynchronously, no frame_done, table cleared, next frame passes data unchanged in fixed mode.

Source files
------------

// File: rtl/rs_codec_pkg.sv
// Shared encodings for the RS error injector: mode codes, frame FSM states,
// and the 16-bit LFSR polynomial/seed handling used in random mode.
package rs_codec_pkg;

    typedef enum logic [1:0] {
        MODE_PASS     = 2'b00,
        MODE_FIXED    = 2'b01,
        MODE_RAND     = 2'b10,
        MODE_PASS_ALT = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] fix_seed(input logic [15:0] seed);
        return (seed == 16'h0000) ? 16'h0001 : seed;
    endfunction

endpackage

// File: rtl/rs_lfsr16.sv
// 16-bit Fibonacci LFSR; advances by one state whenever step is high.
module rs_lfsr16
    import rs_codec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= fix_seed(seed);
        end else if (step) begin
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/rs_err_injector.sv
// Corrupts symbols of a Reed-Solomon codeword stream, either from a small
// position/pattern table or pseudo-randomly, one frame per start request.
module rs_err_injector
    import rs_codec_pkg::*;
#(
    parameter int          SYM_W     = 4,
    parameter int          FRAME_LEN = 15,
    parameter int          MAX_ERR   = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         IDX_W     = (MAX_ERR > 1) ? $clog2(MAX_ERR) : 1,
    localparam int         CNT_W     = $clog2(MAX_ERR + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_impulse,
    input  logic [SYM_W-1:0] data_in,
    input  logic [1:0]       mode,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [7:0]       cfg_pos,
    input  logic [SYM_W-1:0] cfg_pat,
    input  logic             cfg_en,
    input  logic [7:0]       rnd_thr,
    output logic [SYM_W-1:0] data_out,
    output logic             err,
    output logic             start_imp,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun,
    output logic [CNT_W-1:0] err_cnt
);

    state_t             state, state_nx;
    logic [7:0]         sym_idx;
    logic               start_frame, last_sym;

    logic [MAX_ERR-1:0] tbl_en, sh_en;
    logic [7:0]         tbl_pos [MAX_ERR];
    logic [7:0]         sh_pos  [MAX_ERR];
    logic [SYM_W-1:0]   tbl_pat [MAX_ERR];
    logic [SYM_W-1:0]   sh_pat  [MAX_ERR];
    mode_t              sh_mode;
    logic [7:0]         sh_thr;

    logic [15:0]        lfsr_q;
    logic               lfsr_unused;
    logic [SYM_W-1:0]   fixed_mask, rnd_pat, mask;
    logic               rnd_hit;

    assign start_frame = (state == ST_IDLE) && start_impulse;
    assign last_sym    = (sym_idx == 8'(FRAME_LEN - 1));
    assign busy        = (state != ST_IDLE);
    assign frame_done  = (state == ST_DONE);
    assign lfsr_unused = ^(lfsr_q >> (SYM_W + 8));

    rs_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (state == ST_RUN),
        .seed (LFSR_SEED),
        .q    (lfsr_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            sym_idx <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_RUN && !last_sym) begin
                sym_idx <= sym_idx + 8'd1;
            end else begin
                sym_idx <= '0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start_impulse) state_nx = ST_RUN;
            ST_RUN:  if (last_sym) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Live table is writable any time; the frame only ever sees the shadow copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_en <= '0;
            sh_en  <= '0;
            for (int i = 0; i < MAX_ERR; i++) begin
                tbl_pos[i] <= '0;
                tbl_pat[i] <= '0;
                sh_pos[i]  <= '0;
                sh_pat[i]  <= '0;
            end
            sh_mode <= MODE_PASS;
            sh_thr  <= '0;
        end else begin
            if (cfg_we && (int'(cfg_idx) < MAX_ERR)) begin
                tbl_en[cfg_idx]  <= cfg_en;
                tbl_pos[cfg_idx] <= cfg_pos;
                tbl_pat[cfg_idx] <= cfg_pat;
            end
            if (start_frame) begin
                sh_en   <= tbl_en;
                sh_pos  <= tbl_pos;
                sh_pat  <= tbl_pat;
                sh_mode <= mode_t'(mode);
                sh_thr  <= rnd_thr;
            end
        end
    end

    always_comb begin
        fixed_mask = '0;
        for (int i = 0; i < MAX_ERR; i++) begin
            if (sh_en[i] && sh_pos[i] == sym_idx) fixed_mask = fixed_mask ^ sh_pat[i];
        end
        rnd_pat = lfsr_q[SYM_W+7:8];
        if (rnd_pat == '0) rnd_pat = SYM_W'(1);
        rnd_hit = (lfsr_q[7:0] < sh_thr) && (err_cnt < CNT_W'(MAX_ERR));
        mask = '0;
        if (state == ST_RUN) begin
            case (sh_mode)
                MODE_FIXED: mask = fixed_mask;
                MODE_RAND:  mask = rnd_hit ? rnd_pat : '0;
                default:    mask = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            err       <= 1'b0;
            start_imp <= 1'b0;
            overrun   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            data_out  <= data_in ^ mask;
            err       <= (mask != '0);
            start_imp <= (state == ST_RUN) && (sym_idx == 8'd0);
            if (busy && start_impulse) overrun <= 1'b1;
            if (start_frame) begin
                err_cnt <= '0;
            end else if ((mask != '0) && (err_cnt < CNT_W'(MAX_ERR))) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rs_err_injector.sv
// Frame-level bench for rs_err_injector: drives whole frames, predicts every
// output symbol from a table/LFSR model and compares via an expected queue.
module tb_rs_err_injector;
    import rs_codec_pkg::*;

    localparam int          SYM_W     = 4;
    localparam int          FRAME_LEN = 15;
    localparam int          MAX_ERR   = 2;
    localparam logic [15:0] SEED      = 16'hACE1;
    localparam int          IDX_W     = 1;
    localparam int          CNT_W     = 2;
    localparam int          EXP_W     = SYM_W + 2;

    logic             clk, rst, start_impulse, cfg_we, cfg_en;
    logic [SYM_W-1:0] data_in, cfg_pat, data_out;
    logic [1:0]       mode;
    logic [IDX_W-1:0] cfg_idx;
    logic [7:0]       cfg_pos, rnd_thr;
    logic             err, start_imp, busy, frame_done, overrun;
    logic [CNT_W-1:0] err_cnt;

    logic [EXP_W-1:0] exp_q[$];
    int               checks, failures;

    logic             m_en  [MAX_ERR];
    logic [7:0]       m_pos [MAX_ERR];
    logic [SYM_W-1:0] m_pat [MAX_ERR];
    logic [15:0]      m_lfsr;
    logic             m_overrun;

    rs_err_injector #(
        .SYM_W(SYM_W), .FRAME_LEN(FRAME_LEN), .MAX_ERR(MAX_ERR), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start_impulse(start_impulse), .data_in(data_in),
        .mode(mode), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pos(cfg_pos),
        .cfg_pat(cfg_pat), .cfg_en(cfg_en), .rnd_thr(rnd_thr),
        .data_out(data_out), .err(err), .start_imp(start_imp), .busy(busy),
        .frame_done(frame_done), .overrun(overrun), .err_cnt(err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MAX_ERR; i++) begin
            m_en[i]  = 1'b0;
            m_pos[i] = '0;
            m_pat[i] = '0;
        end
        m_lfsr    = SEED;
        m_overrun = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_start_imp"}, start_imp, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    task automatic cfg_write(input int idx, input int pos, input int pat, input logic en);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_pos = 8'(pos);
        cfg_pat = SYM_W'(pat); cfg_en = en;
        m_en[idx] = en; m_pos[idx] = 8'(pos); m_pat[idx] = SYM_W'(pat);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // const_data < 0 means random symbols; pulse_at/cfg_at/rst_at < 0 disable those events.
    task automatic run_frame(input logic [1:0] md, input logic [7:0] thr, input int const_data,
                             input int pulse_at, input int cfg_at, input int rst_at,
                             output int errs, output logic [FRAME_LEN-1:0] err_map);
        logic             s_en  [MAX_ERR];
        logic [7:0]       s_pos [MAX_ERR];
        logic [SYM_W-1:0] s_pat [MAX_ERR];
        logic [SYM_W-1:0] d, m, rp;
        logic [EXP_W-1:0] e;
        int               cnt;
        cnt = 0;
        err_map = '0;
        @(negedge clk);
        mode = md; rnd_thr = thr; start_impulse = 1'b1;
        data_in = SYM_W'($urandom_range(0, 15));
        s_en = m_en; s_pos = m_pos; s_pat = m_pat;
        @(negedge clk);
        start_impulse = 1'b0;
        for (int k = 0; k < FRAME_LEN; k++) begin
            cfg_we = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check_all_zero("midrst");
                model_reset();
                exp_q.delete();
                @(negedge clk);
                rst = 1'b0;
                errs = cnt;
                return;
            end
            start_impulse = (k == pulse_at);
            if (k == pulse_at) m_overrun = 1'b1;
            if (k == cfg_at) begin
                cfg_we = 1'b1; cfg_idx = '0; cfg_pos = 8'd2; cfg_pat = 4'h6; cfg_en = 1'b1;
                m_en[0] = 1'b1; m_pos[0] = 8'd2; m_pat[0] = 4'h6;
            end
            mode    = 2'($urandom_range(0, 3));
            rnd_thr = 8'($urandom_range(0, 255));
            d = (const_data >= 0) ? SYM_W'(const_data) : SYM_W'($urandom_range(0, 15));
            data_in = d;
            m = '0;
            if (md == 2'b01) begin
                for (int i = 0; i < MAX_ERR; i++)
                    if (s_en[i] && s_pos[i] == 8'(k)) m = m ^ s_pat[i];
            end else if (md == 2'b10) begin
                rp = m_lfsr[SYM_W+7:8];
                if (rp == '0) rp = SYM_W'(1);
                if (m_lfsr[7:0] < thr && cnt < MAX_ERR) m = rp;
            end
            m_lfsr = lfsr_next(m_lfsr);
            if (m != '0 && cnt < MAX_ERR) cnt++;
            exp_q.push_back({(k == 0), (m != '0), d ^ m});
            @(negedge clk);
            e = exp_q.pop_front();
            err_map[k] = err;
            check($sformatf("sym%0d_{start,err,data}", k), {start_imp, err, data_out}, e);
            check($sformatf("sym%0d_frame_done", k), frame_done, (k == FRAME_LEN - 1));
            check($sformatf("sym%0d_busy", k), busy, 1);
            check($sformatf("sym%0d_overrun", k), overrun, m_overrun);
        end
        cfg_we = 1'b0;
        check("done_err_cnt", err_cnt, cnt);
        d = SYM_W'($urandom_range(0, 15));
        data_in = d;
        @(negedge clk);
        check("idle_{err,data}", {err, data_out}, {1'b0, d});
        check("idle_busy", busy, 0);
        check("idle_frame_done", frame_done, 0);
        check("idle_err_cnt_hold", err_cnt, cnt);
        check("idle_overrun", overrun, m_overrun);
        errs = cnt;
    endtask

    int                   errs;
    logic [FRAME_LEN-1:0] emap;

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; start_impulse = 1'b0; data_in = '0; mode = 2'b00;
        cfg_we = 1'b0; cfg_idx = '0; cfg_pos = '0; cfg_pat = '0; cfg_en = 1'b0; rnd_thr = '0;
        model_reset();
        @(negedge clk);
        data_in = 4'hF;
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // random mode straight after reset: LFSR low bytes E1, C3 -> first two symbols hit
        run_frame(2'b10, 8'hFF, -1, -1, -1, -1, errs, emap);
        check("rand_ff_map", emap, 15'h0003);
        check("rand_ff_cnt", errs, 2);
        run_frame(2'b10, 8'h00, -1, -1, -1, -1, errs, emap);
        check("rand_00_map", emap, 15'h0000);
        run_frame(2'b10, 8'h40, -1, -1, -1, -1, errs, emap);

        cfg_write(0, 1, 4'b1000, 1'b1);
        cfg_write(1, 4, 4'b1000, 1'b1);
        run_frame(2'b01, 8'h00, 5, -1, -1, -1, errs, emap);
        check("fixed_map", emap, 15'h0012);
        check("fixed_cnt", errs, 2);
        run_frame(2'b00, 8'hFF, -1, -1, -1, -1, errs, emap);
        check("pass00_map", emap, 15'h0000);
        run_frame(2'b11, 8'hFF, -1, -1, -1, -1, errs, emap);
        check("pass11_map", emap, 15'h0000);

        cfg_write(0, 3, 4'h3, 1'b1);
        cfg_write(1, 3, 4'h3, 1'b1);
        run_frame(2'b01, 8'h00, -1, -1, -1, -1, errs, emap);
        check("cancel_map", emap, 15'h0000);

        cfg_write(0, 15, 4'hF, 1'b1);
        cfg_write(1, 14, 4'h1, 1'b1);
        run_frame(2'b01, 8'h00, -1, -1, -1, -1, errs, emap);
        check("edge_pos_map", emap, 15'h4000);
        cfg_write(0, 5, 4'h7, 1'b0);
        cfg_write(1, 200, 4'h2, 1'b1);
        run_frame(2'b01, 8'h00, -1, -1, -1, -1, errs, emap);
        check("disabled_map", emap, 15'h0000);

        cfg_write(1, 6, 4'h2, 1'b0);
        run_frame(2'b01, 8'h00, -1, -1, 5, -1, errs, emap);
        check("cfg_midframe_n", emap, 15'h0000);
        run_frame(2'b01, 8'h00, -1, -1, -1, -1, errs, emap);
        check("cfg_midframe_n1", emap, 15'h0004);

        run_frame(2'b01, 8'h00, -1, 7, -1, -1, errs, emap);
        check("overrun_sticky", overrun, 1);
        run_frame(2'b10, 8'h80, -1, -1, -1, -1, errs, emap);

        run_frame(2'b01, 8'h00, -1, -1, -1, 9, errs, emap);
        run_frame(2'b01, 8'h00, -1, -1, -1, -1, errs, emap);
        check("after_rst_map", emap, 15'h0000);
        run_frame(2'b10, 8'hFF, -1, -1, -1, -1, errs, emap);
        check("after_rst_rand_map", emap, 15'h0003);

        check("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
